// File: rtl/hazard_detection.sv
// ID-stage hazard unit: detects load-use and unresolved branch-operand hazards, drives
// stall/bubble/flush controls, tracks stall runs and keeps saturating event counters.
module hazard_detection #(
  parameter int unsigned MAX_STALL = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [4:0]       i_if_id_rs,
  input  logic [4:0]       i_if_id_rt,
  input  logic             i_if_id_uses_rt,
  input  logic             i_if_id_is_branch,
  input  logic             i_branch_taken,
  input  logic             i_id_ex_mem_read,
  input  logic             i_id_ex_reg_write,
  input  logic [4:0]       i_id_ex_rd,
  input  logic             i_ex_mem_mem_read,
  input  logic [4:0]       i_ex_mem_rd,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count,
  output logic             o_stall_timeout
);

  localparam int unsigned RunW = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

  state_e            r_state, w_state_d;
  logic [RunW-1:0]   r_run_len, w_run_len_d;
  logic [CNT_W-1:0]  r_stall_count, r_flush_count;
  logic              r_stall_timeout;

  logic w_match_ex, w_match_mem;
  logic w_h1, w_h2, w_h3, w_hazard, w_flush;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic f_match(input logic [4:0] r, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic uses_rt);
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  assign w_match_ex  = f_match(i_id_ex_rd, i_if_id_rs, i_if_id_rt, i_if_id_uses_rt);
  assign w_match_mem = f_match(i_ex_mem_rd, i_if_id_rs, i_if_id_rt, i_if_id_uses_rt);

  assign w_h1     = i_id_ex_mem_read && w_match_ex;
  assign w_h2     = i_if_id_is_branch && i_id_ex_reg_write && !i_id_ex_mem_read && w_match_ex;
  assign w_h3     = i_if_id_is_branch && i_ex_mem_mem_read && w_match_mem;
  assign w_hazard = w_h1 || w_h2 || w_h3;

  // A stall masks branchTaken; a flush is never repeated back to back.
  assign w_flush  = i_if_id_is_branch && i_branch_taken && !w_hazard && (r_state != StFlush);

  always_comb begin
    w_state_d   = StRun;
    w_run_len_d = '0;
    if (w_hazard) begin
      w_state_d   = StStall;
      w_run_len_d = (r_run_len == RunW'(MAX_STALL)) ? r_run_len : r_run_len + 1'b1;
    end else if (w_flush) begin
      w_state_d   = StFlush;
    end
  end

  always_comb begin
    o_pc_write     = !w_hazard;
    o_if_id_write  = !w_hazard;
    o_if_id_flush  = w_flush;
    o_id_ex_bubble = w_hazard;
    if (i_reset) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_if_id_flush  = 1'b1;
      o_id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state         <= StRun;
      r_run_len       <= '0;
      r_stall_count   <= '0;
      r_flush_count   <= '0;
      r_stall_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_run_len <= w_run_len_d;
      if (w_hazard && (r_stall_count != '1)) r_stall_count <= r_stall_count + 1'b1;
      if (w_flush && (r_flush_count != '1))  r_flush_count <= r_flush_count + 1'b1;
      if (w_hazard && (w_run_len_d == RunW'(MAX_STALL))) r_stall_timeout <= 1'b1;
    end
  end

  assign o_stall_count   = r_stall_count;
  assign o_flush_count   = r_flush_count;
  assign o_stall_timeout = r_stall_timeout;

endmodule

// File: tb/tb_hazard_detection.sv
// Bench for hazard_detection: directed pipeline scenarios followed by random stimulus,
// all checked against a behavioural model of the hazard rules.
module tb_hazard_detection;

  localparam int unsigned MAX_STALL = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int          CMAX      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs, rt, ex_rd, mem_rd;
  logic             uses_rt, is_br, taken, ex_mr, ex_rw, mem_mr;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, stall_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_stall = 0, m_flush = 0, m_run = 0;
  bit m_in_flush = 0, m_timeout = 0;

  always #5 clk = ~clk;

  hazard_detection #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) u_dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_if_id_rs       (rs),
    .i_if_id_rt       (rt),
    .i_if_id_uses_rt  (uses_rt),
    .i_if_id_is_branch(is_br),
    .i_branch_taken   (taken),
    .i_id_ex_mem_read (ex_mr),
    .i_id_ex_reg_write(ex_rw),
    .i_id_ex_rd       (ex_rd),
    .i_ex_mem_mem_read(mem_mr),
    .i_ex_mem_rd      (mem_rd),
    .o_pc_write       (pc_write),
    .o_if_id_write    (if_id_write),
    .o_if_id_flush    (if_id_flush),
    .o_id_ex_bubble   (id_ex_bubble),
    .o_stall_count    (stall_count),
    .o_flush_count    (flush_count),
    .o_stall_timeout  (stall_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit reads(input logic [4:0] r);
    return r != 0 && (r == rs || (uses_rt && r == rt));
  endfunction

  function automatic bit m_hazard();
    bit load_use   = ex_mr && reads(ex_rd);
    bit br_alu     = is_br && ex_rw && !ex_mr && reads(ex_rd);
    bit br_load    = is_br && mem_mr && reads(mem_rd);
    return load_use || br_alu || br_load;
  endfunction

  task automatic nop_inputs();
    rst = 0; rs = 0; rt = 0; ex_rd = 0; mem_rd = 0;
    uses_rt = 0; is_br = 0; taken = 0; ex_mr = 0; ex_rw = 0; mem_mr = 0;
  endtask

  // Called at a negedge with inputs already driven; checks, then advances one cycle.
  task automatic step();
    bit hz, fl;
    #1;
    hz = m_hazard();
    fl = is_br && taken && !hz && !m_in_flush;
    check("pc_write",    pc_write,     rst ? 0 : !hz);
    check("if_id_write", if_id_write,  rst ? 0 : !hz);
    check("id_ex_bubble", id_ex_bubble, rst ? 1 : hz);
    check("if_id_flush", if_id_flush,  rst ? 1 : fl);
    check("stall_count", stall_count,  m_stall);
    check("flush_count", flush_count,  m_flush);
    check("stall_timeout", stall_timeout, m_timeout);
    @(posedge clk);
    if (rst) begin
      m_stall = 0; m_flush = 0; m_run = 0; m_in_flush = 0; m_timeout = 0;
    end else if (hz) begin
      if (m_stall < CMAX) m_stall++;
      if (m_run < MAX_STALL) m_run++;
      if (m_run == MAX_STALL) m_timeout = 1;
      m_in_flush = 0;
    end else begin
      if (fl && m_flush < CMAX) m_flush++;
      m_in_flush = fl;
      m_run = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    nop_inputs(); rst = 1; step(); step(); rst = 0;
  endtask

  initial begin
    nop_inputs();
    rst = 1;
    @(negedge clk);
    do_reset();

    // T1: load-use on rs
    ex_mr = 1; ex_rw = 1; ex_rd = 8; rs = 8; step();
    nop_inputs(); step();
    check("t1_stall_count", stall_count, 1);

    // T2: lw $9 then beq rs=9 -> two stalls, then taken branch flushes (state back to RUN)
    do_reset();
    is_br = 1; rs = 9; ex_mr = 1; ex_rw = 1; ex_rd = 9; step();
    ex_mr = 0; ex_rw = 0; ex_rd = 0; mem_mr = 1; mem_rd = 9; step();
    mem_mr = 0; mem_rd = 0; taken = 1; step();
    check("t2_stall_count", stall_count, 2);
    check("t2_flush_count", flush_count, 1);

    // T3: $0 destination never stalls
    do_reset();
    ex_mr = 1; ex_rd = 0; rs = 0; step();
    check("t3_stall_count", stall_count, 0);

    // T4a: taken branch flushes for exactly one cycle; T4b: H2 suppresses flush
    do_reset();
    is_br = 1; taken = 1; rs = 3; step(); step(); step();
    check("t4a_flush_count", flush_count, 2);
    ex_rw = 1; ex_rd = 3; step();
    nop_inputs(); step();

    // T5: held load-use raises sticky timeout
    do_reset();
    ex_mr = 1; ex_rd = 5; rt = 5; uses_rt = 1;
    for (int i = 0; i < 6; i++) step();
    nop_inputs(); step(); step();
    check("t5_timeout_sticky", stall_timeout, 1);

    // T6: reset in the middle of a T2-style run
    do_reset();
    is_br = 1; rs = 9; ex_mr = 1; ex_rw = 1; ex_rd = 9; step();
    ex_mr = 0; ex_rw = 0; ex_rd = 0; mem_mr = 1; mem_rd = 9; rst = 1; step();
    nop_inputs(); is_br = 1; taken = 1; step();
    check("t6_stall_count", stall_count, 0);

    // Random phase: small register space so matches are frequent
    for (int i = 0; i < 1500; i++) begin
      rst     = ($urandom_range(0, 149) == 0);
      rs      = 5'($urandom_range(0, 3));
      rt      = 5'($urandom_range(0, 3));
      ex_rd   = 5'($urandom_range(0, 3));
      mem_rd  = 5'($urandom_range(0, 3));
      uses_rt = 1'($urandom_range(0, 1));
      is_br   = 1'($urandom_range(0, 1));
      taken   = 1'($urandom_range(0, 1));
      ex_mr   = ($urandom_range(0, 3) == 0);
      ex_rw   = 1'($urandom_range(0, 1));
      mem_mr  = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
